// File: rtl/dmem_access.sv
// dmem_access: RV32I memory stage with byte-lane data RAM; DMEM_MISALIGN_SPLIT_EN enables the two-cycle misaligned split
module dmem_access #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_we_i,
    input  logic [3:0]            mem_op_i,
    input  logic [4:0]            reg_waddr_i,
    input  logic                  reg_we_i,
    input  logic [DATA_WIDTH-1:0] reg_wdata_i,
    output logic [4:0]            reg_waddr_o,
    output logic                  reg_we_o,
    output logic [DATA_WIDTH-1:0] reg_wdata_o,
    output logic                  stallreq_o,
    output logic                  misalign_o
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] MEM_NOP = 4'd0;
    localparam logic [3:0] MEM_LB  = 4'd1;
    localparam logic [3:0] MEM_LH  = 4'd2;
    localparam logic [3:0] MEM_LW  = 4'd3;
    localparam logic [3:0] MEM_LBU = 4'd4;
    localparam logic [3:0] MEM_LHU = 4'd5;
    localparam logic [3:0] MEM_SB  = 4'd6;
    localparam logic [3:0] MEM_SH  = 4'd7;
    localparam logic [3:0] MEM_SW  = 4'd8;

    logic [31:0]   ram [DEPTH_WORDS];
    logic [1:0]    off;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_nx;
    logic          is_ld;
    logic          is_st;
    logic          mis;
    logic [3:0]    size_be;
    logic [7:0]    be;
    logic [63:0]   wd;
    logic          in_split;
    logic          drop;
    logic          wr_lo;
    logic          wr_hi;
    logic [31:0]   lo_q;
    logic [31:0]   hi_q;
    logic [31:0]   alu_q;
    logic [3:0]    op_q;
    logic [1:0]    off_q;
    logic          ld_q;
    logic [31:0]   sh;
    logic          unused_addr;

    assign off         = mem_addr_i[1:0];
    assign idx         = mem_addr_i[IW+1:2];
    assign idx_nx      = idx + IW'(1);
    assign unused_addr = ^mem_addr_i[ADDR_WIDTH-1:IW+2];

    // Decode the op: class, misalignment, and the store lane mask/data spread over two words
    always_comb begin
        is_ld   = mem_op_i inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
        is_st   = mem_op_i inside {MEM_SB, MEM_SH, MEM_SW};
        mis     = ((mem_op_i == MEM_LW || mem_op_i == MEM_SW) && off != 2'd0) ||
                  ((mem_op_i inside {MEM_LH, MEM_LHU, MEM_SH}) && off == 2'd3);
        size_be = (mem_op_i == MEM_SW) ? 4'hF : (mem_op_i == MEM_SH) ? 4'h3 : 4'h1;
        be      = {4'b0, size_be} << off;
        wd      = {32'b0, mem_data_i[31:0]} << {off, 3'b000};
    end

`ifdef DMEM_MISALIGN_SPLIT_EN
    typedef enum logic {IDLE, SPLIT} state_t;
    state_t state;
    state_t state_nx;

    // Split-access state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nx;
    end

    // A misaligned access in IDLE stalls upstream and moves to SPLIT for the second word
    always_comb begin
        state_nx   = state;
        stallreq_o = 1'b0;
        if (state == IDLE && mis) begin
            stallreq_o = rst_n_i;
            state_nx   = SPLIT;
        end else if (state == SPLIT) begin
            state_nx = IDLE;
        end
    end

    assign in_split = (state == SPLIT);
    assign drop     = 1'b0;
`else
    assign stallreq_o = 1'b0;
    assign in_split   = 1'b0;
    assign drop       = mis;
`endif

    assign wr_lo = rst_n_i && is_st && mem_we_i && !in_split && !drop;
    assign wr_hi = rst_n_i && is_st && mem_we_i && in_split;

    // Byte-lane RAM writes: the addressed word normally, the following word during SPLIT
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_lo && be[b])   ram[idx][8*b +: 8]    <= wd[8*b +: 8];
            if (wr_hi && be[b+4]) ram[idx_nx][8*b +: 8] <= wd[32+8*b +: 8];
        end
    end

    // Synchronous RAM read; the low word is held while SPLIT fetches the upper word
    always_ff @(posedge clk_i) begin
        if (!in_split) lo_q <= ram[idx];
        else           hi_q <= ram[idx_nx];
    end

    // Writeback pipeline register; write enable only for NOP and completed loads
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            reg_waddr_o <= 5'd0;
            reg_we_o    <= 1'b0;
            alu_q       <= 32'd0;
            op_q        <= MEM_NOP;
            off_q       <= 2'd0;
            ld_q        <= 1'b0;
            misalign_o  <= 1'b0;
        end else begin
            reg_waddr_o <= reg_waddr_i;
            reg_we_o    <= reg_we_i && (mem_op_i == MEM_NOP || (is_ld && (in_split || !mis)));
            alu_q       <= reg_wdata_i[31:0];
            op_q        <= mem_op_i;
            off_q       <= off;
            ld_q        <= is_ld;
            misalign_o  <= drop;
        end
    end

    // Align the fetched word(s) to the start lane and extend per load type
    always_comb begin
        sh          = 32'({hi_q, lo_q} >> {off_q, 3'b000});
        reg_wdata_o = !ld_q            ? alu_q :
                      op_q == MEM_LB   ? {{24{sh[7]}}, sh[7:0]} :
                      op_q == MEM_LH   ? {{16{sh[15]}}, sh[15:0]} :
                      op_q == MEM_LBU  ? {24'd0, sh[7:0]} :
                      op_q == MEM_LHU  ? {16'd0, sh[15:0]} : sh;
    end
endmodule

// File: tb/tb_dmem_access.sv
// tb_dmem_access: randomized and directed self-checking bench for dmem_access against a byte-array memory model
module tb_dmem_access;
    localparam logic [3:0] NOP = 4'd0, LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4,
                           LHU = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;
`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n_i = 1'b1;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_data_i = '0;
    logic        mem_we_i = 1'b0;
    logic [3:0]  mem_op_i = '0;
    logic [4:0]  reg_waddr_i = '0;
    logic        reg_we_i = 1'b0;
    logic [31:0] reg_wdata_i = '0;
    logic [4:0]  reg_waddr_o;
    logic        reg_we_o;
    logic [31:0] reg_wdata_o;
    logic        stallreq_o;
    logic        misalign_o;

    int checks = 0;
    int errors = 0;
    logic [7:0] mdl [4096];

    dmem_access dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .mem_we_i(mem_we_i), .mem_op_i(mem_op_i), .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i),
        .reg_wdata_i(reg_wdata_i), .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o),
        .reg_wdata_o(reg_wdata_o), .stallreq_o(stallreq_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    localparam logic [3:0]  T_OP   [12] = '{SW, LW, SB, LB, LBU, LW, SH, LH, LHU, NOP, 4'hC, LW};
    localparam logic [31:0] T_ADDR [12] = '{32'h100, 32'h100, 32'h103, 32'h103, 32'h103, 32'h100,
                                            32'h102, 32'h102, 32'h102, 32'h0, 32'h100, 32'h100};
    localparam logic [31:0] T_DATA [12] = '{32'hDEADBEEF, 32'h12345678, 32'h00000080, 32'h12345678,
                                            32'h12345678, 32'h12345678, 32'h00008001, 32'h12345678,
                                            32'h12345678, 32'h00000055, 32'h00000077, 32'h12345678};
    localparam logic [4:0]  T_RD   [12] = '{5'd1, 5'd5, 5'd2, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd3, 5'd12, 5'd13};
    localparam logic        T_WE   [12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    localparam logic [31:0] T_EXP  [12] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'hFFFFFF80, 32'h00000080,
                                            32'h80ADBEEF, 32'h0, 32'hFFFF8001, 32'h00008001,
                                            32'h00000055, 32'h00000077, 32'h8001BEEF};

    task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic mwe, input logic [4:0] rd, input logic rwe);
        mem_op_i = op; mem_addr_i = addr; mem_data_i = data; reg_wdata_i = data;
        mem_we_i = mwe; reg_waddr_i = rd; reg_we_i = rwe;
    endtask

    function automatic bit mdl_mis(input logic [3:0] op, input logic [11:0] a);
        return ((op == LW || op == SW) && a % 4 != 0) || ((op == LH || op == LHU || op == SH) && a % 4 == 3);
    endfunction

    function automatic logic [31:0] mdl_load(input logic [3:0] op, input logic [11:0] a);
        logic [31:0] w;
        w = {mdl[12'(a + 12'd3)], mdl[12'(a + 12'd2)], mdl[12'(a + 12'd1)], mdl[a]};
        case (op)
            LB:      return {{24{w[7]}}, w[7:0]};
            LH:      return {{16{w[15]}}, w[15:0]};
            LBU:     return {24'd0, w[7:0]};
            LHU:     return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic mdl_store(input logic [3:0] op, input logic [11:0] a, input logic [31:0] d);
        int n;
        n = (op == SW) ? 4 : (op == SH) ? 2 : 1;
        for (int k = 0; k < n; k++) mdl[12'(a + 12'(k))] = d[8*k +: 8];
    endtask

    task automatic test_reset;
        drive(LW, 32'h101, 32'h0, 1'b1, 5'd31, 1'b1);
        @(negedge clk); @(negedge clk);
        checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stallreq_o); end
        checks++; if (reg_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", reg_we_o); end
        checks++; if (reg_waddr_o !== 5'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", reg_waddr_o); end
        checks++; if (reg_wdata_o !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h want 0", reg_wdata_o); end
        checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b want 0", misalign_o); end
        drive(NOP, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        rst_n_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_load;
        for (int i = 0; i < 12; i++) begin
            drive(T_OP[i], T_ADDR[i], T_DATA[i], 1'b1, T_RD[i], 1'b1);
            @(negedge clk);
            checks++; if (reg_we_o !== T_WE[i]) begin errors++; $display("FAIL sl%0d_we got %b want %b", i, reg_we_o, T_WE[i]); end
            checks++; if (reg_waddr_o !== T_RD[i]) begin errors++; $display("FAIL sl%0d_waddr got %0d want %0d", i, reg_waddr_o, T_RD[i]); end
            if (!(T_OP[i] inside {SB, SH, SW})) begin
                checks++; if (reg_wdata_o !== T_EXP[i]) begin errors++; $display("FAIL sl%0d_wdata got %h want %h", i, reg_wdata_o, T_EXP[i]); end
            end
        end
    endtask

    task automatic test_misalign;
        drive(SW, 32'h100, 32'h11223344, 1'b1, 5'd0, 1'b0); @(negedge clk);
        drive(SW, 32'h104, 32'h55667788, 1'b1, 5'd0, 1'b0); @(negedge clk);
        drive(SW, 32'h101, 32'hAABBCCDD, 1'b1, 5'd4, 1'b1);
        #1;
        checks++; if (stallreq_o !== SPLIT) begin errors++; $display("FAIL mis_sw_stall got %b want %b", stallreq_o, SPLIT); end
        @(negedge clk);
        checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL mis_sw_stall2 got %b want 0", stallreq_o); end
        checks++; if (reg_we_o !== 1'b0) begin errors++; $display("FAIL mis_sw_we got %b want 0", reg_we_o); end
        checks++; if (misalign_o !== !SPLIT) begin errors++; $display("FAIL mis_sw_pulse got %b want %b", misalign_o, !SPLIT); end
`ifdef DMEM_MISALIGN_SPLIT_EN
        @(negedge clk);
`endif
        drive(LW, 32'h100, 32'h0, 1'b0, 5'd5, 1'b1); @(negedge clk);
        checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL mis_pulse_end got %b want 0", misalign_o); end
        checks++; if (reg_wdata_o !== (SPLIT ? 32'hBBCCDD44 : 32'h11223344)) begin errors++; $display("FAIL mis_lo_word got %h", reg_wdata_o); end
        drive(LW, 32'h104, 32'h0, 1'b0, 5'd5, 1'b1); @(negedge clk);
        checks++; if (reg_wdata_o !== (SPLIT ? 32'h556677AA : 32'h55667788)) begin errors++; $display("FAIL mis_hi_word got %h", reg_wdata_o); end
        drive(LW, 32'h101, 32'h0, 1'b0, 5'd6, 1'b1);
        #1;
        checks++; if (stallreq_o !== SPLIT) begin errors++; $display("FAIL mis_lw_stall got %b want %b", stallreq_o, SPLIT); end
        @(negedge clk);
        checks++; if (reg_we_o !== 1'b0) begin errors++; $display("FAIL mis_lw_bubble got %b want 0", reg_we_o); end
`ifdef DMEM_MISALIGN_SPLIT_EN
        @(negedge clk);
        checks++; if (reg_we_o !== 1'b1) begin errors++; $display("FAIL mis_lw_we got %b want 1", reg_we_o); end
        checks++; if (reg_wdata_o !== 32'hAABBCCDD) begin errors++; $display("FAIL mis_lw_data got %h want aabbccdd", reg_wdata_o); end
`else
        checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL mis_lw_pulse got %b want 1", misalign_o); end
`endif
    endtask

    task automatic test_wrap;
        drive(SW, 32'h1000, 32'hCAFEF00D, 1'b1, 5'd0, 1'b0); @(negedge clk);
        drive(LW, 32'h0, 32'h0, 1'b0, 5'd7, 1'b1); @(negedge clk);
        checks++; if (reg_wdata_o !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap_lw0 got %h want cafef00d", reg_wdata_o); end
        drive(LW, 32'h7000_0000, 32'h0, 1'b0, 5'd7, 1'b1); @(negedge clk);
        checks++; if (reg_wdata_o !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap_hiaddr got %h want cafef00d", reg_wdata_o); end
    endtask

    task automatic test_reset_mid;
        drive(SW, 32'h200, 32'h0, 1'b1, 5'd0, 1'b0); @(negedge clk);
        drive(SW, 32'h204, 32'h0, 1'b1, 5'd0, 1'b0); @(negedge clk);
        drive(SW, 32'h202, 32'h12345678, 1'b1, 5'd9, 1'b1); @(negedge clk);
        rst_n_i = 1'b0;
        #1;
        checks++; if (reg_we_o !== 1'b0) begin errors++; $display("FAIL rmid_we got %b want 0", reg_we_o); end
        checks++; if (reg_waddr_o !== 5'd0) begin errors++; $display("FAIL rmid_waddr got %0d want 0", reg_waddr_o); end
        checks++; if (reg_wdata_o !== 32'd0) begin errors++; $display("FAIL rmid_wdata got %h want 0", reg_wdata_o); end
        checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL rmid_misalign got %b want 0", misalign_o); end
        @(negedge clk);
        checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL rmid_stall got %b want 0", stallreq_o); end
        drive(NOP, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        rst_n_i = 1'b1;
        @(negedge clk);
        drive(LW, 32'h200, 32'h0, 1'b0, 5'd10, 1'b1);
        #1;
        checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL rmid_idle got %b want 0", stallreq_o); end
        @(negedge clk);
        checks++; if (reg_wdata_o !== (SPLIT ? 32'h56780000 : 32'h0)) begin errors++; $display("FAIL rmid_lo got %h", reg_wdata_o); end
        drive(LW, 32'h204, 32'h0, 1'b0, 5'd10, 1'b1); @(negedge clk);
        checks++; if (reg_wdata_o !== 32'h0) begin errors++; $display("FAIL rmid_hi got %h want 0", reg_wdata_o); end
    endtask

    task automatic test_random;
        logic [3:0]  op;
        logic [11:0] a;
        logic [31:0] d;
        logic [4:0]  rd;
        logic        mwe, rwe, mis, ld, st, exp_we;
        for (int w = 0; w < 31; w++) begin
            a = (w < 15) ? 12'(w * 4) : 12'(12'hFC0 + (w - 15) * 4);
            d = $urandom();
            drive(SW, 32'(a), d, 1'b1, 5'd0, 1'b0); @(negedge clk);
            mdl_store(SW, a, d);
        end
        for (int i = 0; i < 400; i++) begin
            op  = 4'($urandom_range(0, 10));
            if (op > 4'd8) op = 4'($urandom_range(9, 15));
            a   = $urandom_range(0, 1) ? 12'($urandom_range(0, 55)) : 12'($urandom_range(12'hFC0, 12'hFFF));
            d   = $urandom();
            rd  = 5'($urandom());
            mwe = $urandom_range(0, 3) != 0;
            rwe = $urandom_range(0, 3) != 0;
            mis = mdl_mis(op, a);
            ld  = op inside {LB, LH, LW, LBU, LHU};
            st  = op inside {SB, SH, SW};
            exp_we = rwe && (op == NOP || (ld && !(mis && !SPLIT)));
            drive(op, ($urandom() & 32'hFFFF_F000) | 32'(a), d, mwe, rd, rwe);
            #1;
            checks++; if (stallreq_o !== (SPLIT && mis)) begin errors++; $display("FAIL rnd%0d_stall got %b want %b", i, stallreq_o, SPLIT && mis); end
            if (SPLIT && mis) begin
                @(negedge clk);
                checks++; if (reg_we_o !== 1'b0) begin errors++; $display("FAIL rnd%0d_bubble got %b want 0", i, reg_we_o); end
            end
            @(negedge clk);
            checks++; if (reg_we_o !== exp_we) begin errors++; $display("FAIL rnd%0d_we op %0d got %b want %b", i, op, reg_we_o, exp_we); end
            checks++; if (reg_waddr_o !== rd) begin errors++; $display("FAIL rnd%0d_waddr got %0d want %0d", i, reg_waddr_o, rd); end
            checks++; if (misalign_o !== (!SPLIT && mis)) begin errors++; $display("FAIL rnd%0d_misalign got %b want %b", i, misalign_o, !SPLIT && mis); end
            if (!ld && !st) begin
                checks++; if (reg_wdata_o !== d) begin errors++; $display("FAIL rnd%0d_pass got %h want %h", i, reg_wdata_o, d); end
            end
            if (ld && !(mis && !SPLIT)) begin
                checks++; if (reg_wdata_o !== mdl_load(op, a)) begin errors++; $display("FAIL rnd%0d_load op %0d a %h got %h want %h", i, op, a, reg_wdata_o, mdl_load(op, a)); end
            end
            if (st && mwe && !(mis && !SPLIT)) mdl_store(op, a, d);
        end
    endtask

    initial begin
        #2 rst_n_i = 1'b0;
        test_reset;
        test_store_load;
        test_misalign;
        test_wrap;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_access.md
# dmem_access

Memory-access stage and data-memory responder for the RV32I core. It accepts the load/store requests the execute stage issues (address, store data, write enable, mem op) and performs byte-lane stores into an internal word-organised data RAM. It returns aligned, sign- or zero-extended load data to writeback, registers the non-memory writeback path, and splits word-crossing accesses in two cycles with a stall request.

## Interface
- DEPTH_WORDS, 1024: data RAM depth in 32-bit words (power of two).
- ADDR_WIDTH, 32: byte address width.
- DATA_WIDTH, 32: data width (fixed at 32).

Ports:
- clk_i  in  1  single clock; all state updates on rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- mem_addr_i  in  32  byte address from execute.
- mem_data_i  in  32  store data (low bits used for SB/SH).
- mem_we_i  in  1  store enable.
- mem_op_i  in  4  `MEM_NOP/`LB/`LH/`LW/`LBU/`LHU/`SB/`SH/`SW from defines.v.
- reg_waddr_i  in  5  destination register.
- reg_we_i  in  1  register write enable.
- reg_wdata_i  in  32  ALU result for non-load ops.
- reg_waddr_o  out  5  registered destination to writeback.
- reg_we_o  out  1  registered write enable.
- reg_wdata_o  out  32  load data or registered ALU result.
- stallreq_o  out  1  hold upstream one cycle (split access).
- misalign_o  out  1  one-cycle pulse: misaligned access dropped.

## Operation
- RAM index = mem_addr_i[log2(DEPTH_WORDS)+1:2]; upper bits ignored (wrap modulo DEPTH_WORDS). Little-endian byte lanes. RAM contents are not reset.
- Store: written at the edge only when mem_we_i=1 and op is SB/SH/SW. SB writes lane addr[1:0]; SH writes lanes addr[1:0] and addr[1:0]+1; SW writes all four lanes. Store ops leave reg_we_o=0.
- Load: LB/LH sign-extend, LBU/LHU zero-extend, LW returns full word, starting at lane addr[1:0].
- `MEM_NOP: reg_waddr/we/wdata passed through one register stage.
- Unknown op codes behave as `MEM_NOP with reg_we_o forced 0.
- Misaligned = LW/SW with addr[1:0]≠0, or LH/LHU/SH with addr[1:0]=3. Aligned half and byte accesses never split.
- FSM: IDLE, SPLIT.
  - In IDLE, a misaligned access (with the macro on) asserts stallreq_o combinationally. At the edge, the low word is accessed (lanes addr[1:0]..3 written, or low word captured into a hold register) and the FSM goes to SPLIT.
  - In SPLIT, stallreq_o=0 and the inputs are the same request held by upstream. At the edge, the word at index+1 is accessed (remaining lanes), with wrap at the top of RAM, and the FSM returns to IDLE.
  - Upstream must hold all inputs stable during any cycle with stallreq_o=1.

## Timing
- Reset values: reg_waddr_o=0, reg_we_o=0, reg_wdata_o=0, misalign_o=0, FSM=IDLE. stallreq_o is forced 0 while rst_n_i=0.
- Aligned request presented in cycle N → result visible in cycle N+1 (synchronous RAM read at edge N, then combinational alignment/extension).
- Split request presented in cycle N → reg_we_o=0 bubble in cycle N+1 → result in cycle N+2.
- A store followed by a load to the same word in the next cycle returns the new data: write happens at edge N, read at edge N+1.
- Reset asserted mid-SPLIT: FSM→IDLE and outputs cleared. A low-half store already written stays written.

## Configuration
- DMEM_MISALIGN_SPLIT_EN defined: two-cycle split as above; misalign_o is tied 0.
- Not defined: no SPLIT state and stallreq_o tied 0. A misaligned access is dropped: no RAM write, reg_we_o=0 in cycle N+1, misalign_o=1 for exactly cycle N+1.

## Test plan
- SW 0xDEADBEEF @0x100, then LW @0x100 with rd=5 → cycle after the load: reg_we_o=1, reg_waddr_o=5, reg_wdata_o=0xDEADBEEF.
- SB 0x80 @0x103, then LB @0x103 → 0xFFFFFF80; LBU @0x103 → 0x00000080; LW @0x100 → 0x80ADBEEF.
- SH 0x8001 @0x102 → LH 0xFFFF8001, LHU 0x00008001; MEM_NOP with reg_wdata_i=0x55, rd=3 → next cycle 0x55, rd 3, we 1.
- With EN: SW 0xAABBCCDD @0x101 → stallreq_o=1 for one cycle. Afterwards word 0x100 = 0xBBCCDD<old byte0> and word 0x104 byte0 = 0xAA. LW @0x101 → 0xAABBCCDD two cycles after issue.
- Without EN: same SW → misalign_o pulses one cycle, RAM unchanged, stallreq_o stays 0. LW @0x101 → reg_we_o=0.
- Store to 0x1000 with DEPTH_WORDS=1024 wraps to index 0; LW @0x0 returns it. rst_n_i low during SPLIT → IDLE, all outputs 0 next cycle.
